// File: rtl/grid_position_tracker_if.sv
// Movement link: the movement block proposes a next cell, the tracker returns the committed cell.
interface grid_position_tracker_if;
    logic [2:0] inext;
    logic [2:0] jnext;
    logic       move_valid;
    logic [2:0] iactual;
    logic [2:0] jactual;

    modport master (
        output inext,
        output jnext,
        output move_valid,
        input  iactual,
        input  jactual
    );

    modport slave (
        input  inext,
        input  jnext,
        input  move_valid,
        output iactual,
        output jactual
    );
endinterface

// File: rtl/grid_position_tracker.sv
// Commits accepted moves on an 8x8 grid, tracks visited cells, counts moves and flags the goal.
module grid_position_tracker #(
    parameter int unsigned START_I = 0,
    parameter int unsigned START_J = 0,
    parameter int unsigned GOAL_I  = 7,
    parameter int unsigned GOAL_J  = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    grid_position_tracker_if.slave        mv,
    output logic [63:0]                   visited,
    output logic [7:0]                    move_count,
    output logic                          accepted,
    output logic                          rejected,
    output logic                          busy,
    output logic                          win
);

    localparam logic [2:0]  StartI   = 3'(START_I);
    localparam logic [2:0]  StartJ   = 3'(START_J);
    localparam logic [2:0]  GoalI    = 3'(GOAL_I);
    localparam logic [2:0]  GoalJ    = 3'(GOAL_J);
    localparam logic [63:0] StartMap = 64'd1 << {StartI, StartJ};

    typedef enum logic [1:0] {StIdle, StCheck, StRelease, StWin} state_e;

    state_e      state_q, state_d;
    logic [2:0]  ci_q, ci_d, cj_q, cj_d;
    logic [2:0]  iact_q, iact_d, jact_q, jact_d;
    logic [63:0] visited_q, visited_d;
    logic [7:0]  count_q, count_d;
    logic        acc_q, acc_d, rej_q, rej_d;

    always_comb begin
        state_d   = state_q;
        ci_d      = ci_q;
        cj_d      = cj_q;
        iact_d    = iact_q;
        jact_d    = jact_q;
        visited_d = visited_q;
        count_d   = count_q;
        acc_d     = 1'b0;
        rej_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mv.move_valid) begin
                    if (mv.inext == iact_q && mv.jnext == jact_q) begin
                        rej_d   = 1'b1;
                        state_d = StRelease;
                    end else begin
                        ci_d    = mv.inext;
                        cj_d    = mv.jnext;
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (visited_q[{ci_q, cj_q}]) begin
                    rej_d   = 1'b1;
                    state_d = StRelease;
                end else begin
                    iact_d                 = ci_q;
                    jact_d                 = cj_q;
                    visited_d[{ci_q, cj_q}] = 1'b1;
                    if (count_q != 8'hFF) count_d = count_q + 8'd1;
                    acc_d   = 1'b1;
                    state_d = (ci_q == GoalI && cj_q == GoalJ) ? StWin : StRelease;
                end
            end
            // Held request must be released before another move can start.
            StRelease: begin
                if (!mv.move_valid) state_d = StIdle;
            end
            StWin: begin
                state_d = StWin;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ci_q      <= StartI;
            cj_q      <= StartJ;
            iact_q    <= StartI;
            jact_q    <= StartJ;
            visited_q <= StartMap;
            count_q   <= 8'd0;
            acc_q     <= 1'b0;
            rej_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ci_q      <= ci_d;
            cj_q      <= cj_d;
            iact_q    <= iact_d;
            jact_q    <= jact_d;
            visited_q <= visited_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            rej_q     <= rej_d;
        end
    end

    assign mv.iactual = iact_q;
    assign mv.jactual = jact_q;
    assign visited    = visited_q;
    assign move_count = count_q;
    assign accepted   = acc_q;
    assign rejected   = rej_q;
    assign busy       = (state_q != StIdle);
    assign win        = (state_q == StWin);

endmodule

// File: tb/tb_grid_position_tracker.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor checks each pulse.
module tb_grid_position_tracker;

    localparam int KAccept = 0, KRevisit = 1, KBump = 2, KIgnore = 3;

    typedef struct packed {
        logic        acc;
        logic        rej;
        logic [2:0]  i;
        logic [2:0]  j;
        logic [7:0]  cnt;
        logic [63:0] vis;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [63:0] visited;
    logic [7:0]  move_count;
    logic        accepted, rejected, busy, win;

    grid_position_tracker_if mif ();

    grid_position_tracker dut (
        .clk        (clk),
        .rst        (rst),
        .mv         (mif.slave),
        .visited    (visited),
        .move_count (move_count),
        .accepted   (accepted),
        .rejected   (rejected),
        .busy       (busy),
        .win        (win)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    // Reference model of committed state
    logic [2:0]  m_i, m_j;
    logic [7:0]  m_cnt;
    logic [63:0] m_vis;
    logic        m_win;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (accepted || rejected)) begin
            exp_t e;
            exp_t a;
            a = '{acc: accepted, rej: rejected, i: mif.iactual, j: mif.jactual,
                  cnt: move_count, vis: visited};
            if (sb.size() == 0) begin
                check("unexpected_pulse", 80'(a), 80'(0));
            end else begin
                e = sb.pop_front();
                check("scoreboard", 80'(a), 80'(e));
            end
        end
    end

    task automatic model_reset();
        m_i = 3'd0; m_j = 3'd0; m_cnt = 8'd0; m_vis = 64'h1; m_win = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_state(input string name);
        check({name, "_pos"}, 80'({mif.iactual, mif.jactual}), 80'({m_i, m_j}));
        check({name, "_cnt"}, 80'(move_count), 80'(m_cnt));
        check({name, "_vis"}, 80'(visited), 80'(m_vis));
        check({name, "_win"}, 80'(win), 80'(m_win));
    endtask

    // Hold a request for 'hold' cycles (>= 2), checking pulse timing at edges k and k+1.
    task automatic request(input logic [2:0] i, input logic [2:0] j, input int kind,
                           input int hold, input string name);
        if (kind == KAccept) begin
            m_i = i; m_j = j;
            m_vis[{i, j}] = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            sb.push_back('{acc: 1'b1, rej: 1'b0, i: m_i, j: m_j, cnt: m_cnt, vis: m_vis});
        end else if (kind != KIgnore) begin
            sb.push_back('{acc: 1'b0, rej: 1'b1, i: m_i, j: m_j, cnt: m_cnt, vis: m_vis});
        end
        mif.inext = i; mif.jnext = j; mif.move_valid = 1'b1;
        @(posedge clk); #1;
        check({name, "_edge_k"}, 80'({accepted, rejected, busy}),
              80'({1'b0, kind == KBump, 1'b1}));
        @(posedge clk); #1;
        check({name, "_edge_k1"}, 80'({accepted, rejected}),
              80'({kind == KAccept, kind == KRevisit}));
        if (kind == KAccept && i == 3'd7 && j == 3'd7) m_win = 1'b1;
        repeat (hold - 2) @(posedge clk);
        #1;
        check({name, "_held_busy"}, 80'(busy), 80'(1));
        mif.move_valid = 1'b0;
        @(posedge clk); #1;
        check({name, "_released_busy"}, 80'(busy), 80'(m_win));
        @(posedge clk); #1;
        check_state(name);
    endtask

    initial begin
        mif.inext = 3'd0; mif.jnext = 3'd0; mif.move_valid = 1'b0;
        model_reset();
        do_reset();
        check_state("reset");
        check("reset_busy", 80'({busy, accepted, rejected}), 80'(0));

        request(3'd0, 3'd1, KAccept, 5, "first_move");
        check("first_move_vis_lit", 80'(visited), 80'(64'h3));
        request(3'd0, 3'd0, KRevisit, 3, "revisit");
        request(3'd0, 3'd1, KBump, 3, "bump");

        for (int s = 1; s <= 7; s++) begin
            request(3'(s), 3'(s), KAccept, 2, "walk");
        end
        check("walk_vis_lit", 80'(visited), 80'(64'h8040_2010_0804_0203));
        check("walk_cnt_lit", 80'({move_count, win}), 80'({8'd8, 1'b1}));
        request(3'd7, 3'd6, KIgnore, 3, "in_win");

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_state("rst_in_win");
        check("rst_in_win_busy", 80'(busy), 80'(0));

        // Reset lands on the CHECK cycle; the pending commit must be dropped.
        mif.inext = 3'd1; mif.jnext = 3'd0; mif.move_valid = 1'b1;
        @(posedge clk); #1;
        check("rst_check_busy", 80'(busy), 80'(1));
        rst = 1'b1; mif.move_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_check_noacc", 80'({accepted, rejected, busy}), 80'(0));
        repeat (3) @(posedge clk);
        #1;
        check_state("rst_in_check");
        check("rst_check_vis_lit", 80'(visited), 80'(64'h1));

        check("sb_drained", 80'(sb.size()), 80'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/grid_position_tracker.md
Name: grid_position_tracker

Overview:
- Receiving end of the movement interface. The movement block proposes a next grid cell (inext, jnext) with a valid flag; this block commits accepted moves to the current-position register.
- It keeps an 8x8 visited map, rejects revisits and wall bumps, counts moves and flags arrival at the goal cell.
- It feeds iactual/jactual back to the movement block and exposes the map and status to the display/game logic.

Parameters:
- START_I, 0, row of the start cell after reset
- START_J, 0, column of the start cell after reset
- GOAL_I, 7, row of the goal cell
- GOAL_J, 7, column of the goal cell

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- inext  in  3  proposed next row
- jnext  in  3  proposed next column
- move_valid  in  1  level; 1 = a direction request is present and inext/jnext are meaningful
- iactual  out  3  committed current row
- jactual  out  3  committed current column
- visited  out  64  visited map; bit index = i*8 + j
- move_count  out  8  number of accepted moves, saturating
- accepted  out  1  one-cycle pulse when a move is committed
- rejected  out  1  one-cycle pulse when a request is refused
- busy  out  1  1 whenever state != IDLE
- win  out  1  1 once the goal cell has been committed

Behaviour:
- Reset (rst=1 at a clock edge), regardless of state:
  - iactual=START_I, jactual=START_J
  - visited = only bit START_I*8+START_J set
  - move_count=0; accepted=0; rejected=0; win=0; state=IDLE
- FSM states: IDLE, CHECK, RELEASE, WIN.
- IDLE, move_valid=0: hold.
- IDLE, move_valid=1 and (inext,jnext)==(iactual,jactual) (wall bump from the movement block):
  - rejected=1 for the next cycle
  - go to RELEASE
- IDLE, move_valid=1 and the cell differs:
  - latch the candidate (ci,cj)
  - go to CHECK
- CHECK (exactly one cycle); inputs are ignored here and only the latched candidate is used.
  - If visited[ci*8+cj]=1: rejected=1 for the next cycle; go to RELEASE.
  - Otherwise, on the leaving edge:
    - iactual=ci, jactual=cj
    - set the visited bit
    - move_count+1, saturating at 255
    - accepted=1 for the next cycle
    - if (ci,cj)==(GOAL_I,GOAL_J), go to WIN; else go to RELEASE.
- RELEASE: stay while move_valid=1, so a held button yields exactly one move. Go to IDLE on the first sampled move_valid=0.
- WIN: win=1; position, map and count are frozen; move_valid is ignored. Only rst exits.
- Latency, with move_valid sampled high at edge k:
  - accepted, plus the new iactual/jactual, visible after edge k+1
  - a bump's rejected is visible after edge k
  - a revisit's rejected is visible after edge k+1
- accepted and rejected are never high in the same cycle. Each pulse is exactly one cycle wide.
- Reset mid-operation (any state, including CHECK and WIN) fully restores reset values on that edge; no pending commit survives.
- Diagonal candidates are accepted as presented. Legality of step size is the movement block's responsibility.
- All outputs are registered.

Test Plan:
- Reset with defaults -> iactual=0, jactual=0, visited=64'h1, move_count=0, win=0, busy=0.
- From [0,0], move_valid=1 with (0,1), held 5 cycles -> one accepted pulse; [0,1]; visited=64'h3; move_count=1; busy until move_valid drops.
- From [0,1], request (0,0) -> rejected pulse after CHECK; position, visited and count unchanged.
- At [0,1], request (0,1) (wall bump) -> rejected one cycle after sampling; no CHECK cycle; count unchanged.
- Walk (0,1)->(1,1)->...->(7,7) with release between steps -> win=1 at arrival; a further request (7,6) is ignored; rst=1 mid-WIN -> [0,0], win=0, count=0.
- rst asserted during the CHECK cycle of a fresh move -> no accepted pulse; [START_I,START_J]; visited=64'h1.
